// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_FETCH_WAIT = 4'd1,
      S_IR_LATCH   = 4'd2,
      S_DECODE     = 4'd3,
      S_R_EXEC     = 4'd4,
      S_R_WB       = 4'd5,
      S_BRANCH     = 4'd6,
      S_MEM_ADDR   = 4'd7,
      S_LW_WAIT    = 4'd8,
      S_SW_WAIT    = 4'd9,
      S_LW_WB      = 4'd10,
      S_LUI_WB     = 4'd11,
      S_JUMP       = 4'd12,
      S_HALT       = 4'd13,
      S_ILLEGAL    = 4'd14
   } state_t;

   // Opcodes (instruction bits 31:26)
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (instruction bits 5:0)
   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_BREAK = 6'h0D;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_XOR   = 6'h26;

   // Datapath select encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_LUI    = 2'b10;

endpackage

// File: rtl/mips_mc_control_p_if.sv
// Control <-> datapath bundle: instruction fields and ALU flag in, all controls out.
interface mips_mc_control_p_if #(
   parameter int STATE_W = 8
);
   logic [5:0]         Op;
   logic [5:0]         Funct;
   logic               ALU_ZERO;
   logic               PC_load;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               BranchNe;
   logic               IorD;
   logic               wr;
   logic [1:0]         MemtoReg;
   logic               IR_load;
   logic               MDR_load;
   logic               A_load;
   logic               B_load;
   logic               ALUOut_load;
   logic [1:0]         PCSource;
   logic [1:0]         ALUOp;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic               RegWrite;
   logic               RegDst;
   logic               Halt;
   logic               Illegal;
   logic [STATE_W-1:0] StateOut;

   // Controller side
   modport master (
      input  Op, Funct, ALU_ZERO,
      output PC_load, PCWrite, PCWriteCond, BranchNe, IorD, wr, MemtoReg,
             IR_load, MDR_load, A_load, B_load, ALUOut_load, PCSource, ALUOp,
             ALUSrcA, ALUSrcB, RegWrite, RegDst, Halt, Illegal, StateOut
   );

   // Datapath side
   modport slave (
      output Op, Funct, ALU_ZERO,
      input  PC_load, PCWrite, PCWriteCond, BranchNe, IorD, wr, MemtoReg,
             IR_load, MDR_load, A_load, B_load, ALUOut_load, PCSource, ALUOp,
             ALUSrcA, ALUSrcB, RegWrite, RegDst, Halt, Illegal, StateOut
   );
endinterface

// File: rtl/mips_ctrl_waitcnt.sv
// Memory wait-state counter. done marks the last FETCH_WAIT cycle (MEM_WAIT
// cycles after the fetch issue); done_mem marks the last cycle of a data
// access, whose issue cycle is the first wait cycle itself (MEM_WAIT+1 total).
module mips_ctrl_waitcnt #(
   parameter int MEM_WAIT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done,
   output logic done_mem
);
   localparam logic [3:0] LAST_FETCH = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);
   localparam logic [3:0] LAST_MEM   = 4'(MEM_WAIT);

   logic [3:0] cnt_q, cnt_d;

   // Clear on any state change, count while sitting in a wait state
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (en) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done     = (cnt_q == LAST_FETCH);
   assign done_mem = (cnt_q == LAST_MEM);
endmodule

// File: rtl/mips_mc_control_p.sv
// Multicycle MIPS control FSM with configurable memory wait states,
// BNE, illegal-opcode trap and BREAK halt. Enables are forced low in reset.
module mips_mc_control_p
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 2,
   parameter int STATE_W  = 8
) (
   input  logic                Clk,
   input  logic                Reset,
   mips_mc_control_p_if.master bus
);
   state_t state_q, state_d;
   logic   wait_done, mem_done, cnt_clr, cnt_en;

   logic       pc_write, pc_write_cond, branch_ne, iord, mem_wr;
   logic       ir_load, mdr_load, a_load, b_load, aluout_load;
   logic       alu_src_a, reg_write, reg_dst, halt, illegal;
   logic [1:0] mem_to_reg, pc_source, alu_op, alu_src_b;

   assign cnt_clr = (state_d != state_q);
   assign cnt_en  = (state_q == S_FETCH_WAIT) || (state_q == S_LW_WAIT) ||
                    (state_q == S_SW_WAIT);

   mips_ctrl_waitcnt #(.MEM_WAIT(MEM_WAIT)) u_waitcnt (
      .clk      (Clk),
      .rst_n    (Reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .done     (wait_done),
      .done_mem (mem_done)
   );

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; Op/Funct are only consulted where the IR is valid
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:      state_d = (MEM_WAIT == 0) ? S_IR_LATCH : S_FETCH_WAIT;
         S_FETCH_WAIT: if (wait_done) state_d = S_IR_LATCH;
         S_IR_LATCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_RTYPE: begin
                  case (bus.Funct)
                     FN_ADD, FN_SUB, FN_AND, FN_XOR: state_d = S_R_EXEC;
                     FN_NOP:                         state_d = S_FETCH;
                     FN_BREAK:                       state_d = S_HALT;
                     default:                        state_d = S_ILLEGAL;
                  endcase
               end
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_LUI:         state_d = S_LUI_WB;
               OP_J:           state_d = S_JUMP;
               default:        state_d = S_ILLEGAL;
            endcase
         end
         S_R_EXEC:   state_d = S_R_WB;
         S_MEM_ADDR: state_d = (bus.Op == OP_SW) ? S_SW_WAIT : S_LW_WAIT;
         S_LW_WAIT:  if (mem_done) state_d = S_LW_WB;
         S_SW_WAIT:  if (mem_done) state_d = S_FETCH;
         S_R_WB, S_BRANCH, S_LW_WB, S_LUI_WB, S_JUMP: state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_FETCH;
      endcase
   end

   // Control decode: everything defaults low, each state raises only what it needs
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      iord          = 1'b0;
      mem_wr        = 1'b0;
      mem_to_reg    = M2R_ALUOUT;
      ir_load       = 1'b0;
      mdr_load      = 1'b0;
      a_load        = 1'b0;
      b_load        = 1'b0;
      aluout_load   = 1'b0;
      pc_source     = PCSRC_ALU;
      alu_op        = ALUOP_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      halt          = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         S_FETCH: begin
            pc_write  = 1'b1;
            alu_src_b = SRCB_FOUR;
         end
         S_IR_LATCH: begin
            ir_load  = 1'b1;
            mdr_load = 1'b1;
         end
         S_DECODE: begin
            a_load      = 1'b1;
            b_load      = 1'b1;
            alu_src_b   = SRCB_IMM_SH;
            aluout_load = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a   = 1'b1;
            alu_op      = ALUOP_FUNCT;
            aluout_load = 1'b1;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            branch_ne     = (bus.Op == OP_BNE);
         end
         S_MEM_ADDR: begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRCB_IMM;
            aluout_load = 1'b1;
         end
         // Read data is only valid once the access completes
         S_LW_WAIT: begin
            iord     = 1'b1;
            mdr_load = mem_done;
         end
         S_SW_WAIT: begin
            iord   = 1'b1;
            mem_wr = 1'b1;
         end
         S_LW_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
         end
         S_LUI_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_LUI;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_HALT:    halt    = 1'b1;
         S_ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end

   assign bus.PC_load     = Reset & (pc_write | (pc_write_cond & (bus.ALU_ZERO ^ branch_ne)));
   assign bus.PCWrite     = Reset & pc_write;
   assign bus.PCWriteCond = Reset & pc_write_cond;
   assign bus.wr          = Reset & mem_wr;
   assign bus.IR_load     = Reset & ir_load;
   assign bus.MDR_load    = Reset & mdr_load;
   assign bus.A_load      = Reset & a_load;
   assign bus.B_load      = Reset & b_load;
   assign bus.ALUOut_load = Reset & aluout_load;
   assign bus.RegWrite    = Reset & reg_write;
   assign bus.BranchNe    = branch_ne;
   assign bus.IorD        = iord;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.PCSource    = pc_source;
   assign bus.ALUOp       = alu_op;
   assign bus.ALUSrcA     = alu_src_a;
   assign bus.ALUSrcB     = alu_src_b;
   assign bus.RegDst      = reg_dst;
   assign bus.Halt        = halt;
   assign bus.Illegal     = illegal;
   assign bus.StateOut    = STATE_W'(state_q);
endmodule

// File: tb/tb_mips_mc_control_p.sv
// Bench for mips_mc_control_p: three instances (MEM_WAIT 0, 2, 3) share the
// same instruction stream and are compared cycle by cycle against a
// sequence-level model of the instruction flow.
module tb_mips_mc_control_p;
   logic       clk = 1'b0;
   logic       Reset = 1'b0;
   logic [5:0] op = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   int         total = 0;
   int         bad = 0;
   int         exps [3][0:63];
   int         mw_of [3] = '{0, 2, 3};
   logic [5:0] tab_op [12];
   logic [5:0] tab_fn [12];

   always #5 clk = ~clk;

   mips_mc_control_p_if #(.STATE_W(8)) if0 ();
   mips_mc_control_p_if #(.STATE_W(8)) if2 ();
   mips_mc_control_p_if #(.STATE_W(8)) if3 ();

   assign if0.Op = op;  assign if0.Funct = funct;  assign if0.ALU_ZERO = zero;
   assign if2.Op = op;  assign if2.Funct = funct;  assign if2.ALU_ZERO = zero;
   assign if3.Op = op;  assign if3.Funct = funct;  assign if3.ALU_ZERO = zero;

   mips_mc_control_p #(.MEM_WAIT(0), .STATE_W(8)) u0 (.Clk(clk), .Reset(Reset), .bus(if0));
   mips_mc_control_p #(.MEM_WAIT(2), .STATE_W(8)) u2 (.Clk(clk), .Reset(Reset), .bus(if2));
   mips_mc_control_p #(.MEM_WAIT(3), .STATE_W(8)) u3 (.Clk(clk), .Reset(Reset), .bus(if3));

   logic [24:0] obs [3];
   logic [7:0]  so [3];
   assign obs[0] = {if0.PC_load, if0.PCWrite, if0.PCWriteCond, if0.BranchNe, if0.IorD, if0.wr, if0.MemtoReg, if0.IR_load, if0.MDR_load, if0.A_load, if0.B_load, if0.ALUOut_load, if0.PCSource, if0.ALUOp, if0.ALUSrcA, if0.ALUSrcB, if0.RegWrite, if0.RegDst, if0.Halt, if0.Illegal};
   assign obs[1] = {if2.PC_load, if2.PCWrite, if2.PCWriteCond, if2.BranchNe, if2.IorD, if2.wr, if2.MemtoReg, if2.IR_load, if2.MDR_load, if2.A_load, if2.B_load, if2.ALUOut_load, if2.PCSource, if2.ALUOp, if2.ALUSrcA, if2.ALUSrcB, if2.RegWrite, if2.RegDst, if2.Halt, if2.Illegal};
   assign obs[2] = {if3.PC_load, if3.PCWrite, if3.PCWriteCond, if3.BranchNe, if3.IorD, if3.wr, if3.MemtoReg, if3.IR_load, if3.MDR_load, if3.A_load, if3.B_load, if3.ALUOut_load, if3.PCSource, if3.ALUOp, if3.ALUSrcA, if3.ALUSrcB, if3.RegWrite, if3.RegDst, if3.Halt, if3.Illegal};
   assign so[0] = if0.StateOut;
   assign so[1] = if2.StateOut;
   assign so[2] = if3.StateOut;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Instruction class from the opcode/funct rules
   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) begin
         if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h26) return 0;
         if (f == 6'h00) return 1;
         if (f == 6'h0D) return 2;
         return 8;
      end
      if (o == 6'h04 || o == 6'h05) return 3;
      if (o == 6'h23) return 4;
      if (o == 6'h2B) return 5;
      if (o == 6'h0F) return 6;
      if (o == 6'h02) return 7;
      return 8;
   endfunction

   // Expected state trace for one instance: the instruction repeated back to back
   task automatic build(input int i, input int mw);
      int p;
      int cls;
      int term;
      p = 0;
      cls = classify(op, funct);
      while (p < 64) begin
         int seq[$];
         seq = {};
         term = -1;
         seq.push_back(0);
         repeat (mw) seq.push_back(1);
         seq.push_back(2);
         seq.push_back(3);
         case (cls)
            0: begin seq.push_back(4); seq.push_back(5); end
            2: term = 13;
            3: seq.push_back(6);
            4: begin seq.push_back(7); repeat (mw + 1) seq.push_back(8); seq.push_back(10); end
            5: begin seq.push_back(7); repeat (mw + 1) seq.push_back(9); end
            6: seq.push_back(11);
            7: seq.push_back(12);
            8: term = 14;
            default: ;
         endcase
         foreach (seq[k]) if (p < 64) begin exps[i][p] = seq[k]; p++; end
         if (term >= 0) while (p < 64) begin exps[i][p] = term; p++; end
      end
   endtask

   // Expected control vector for a state, from the per-state control table
   function automatic logic [24:0] exp_outs(input int st, input bit last_lw, input bit in_rst);
      logic pcl, pcw, pcc, bne, iord, wr, ir, mdr, al, bl, aol, srca, rw, rd, hl, il;
      logic [1:0] m2r, pcs, aop, srcb;
      {pcw, pcc, bne, iord, wr, ir, mdr, al, bl, aol, srca, rw, rd, hl, il} = '0;
      {m2r, pcs, aop, srcb} = '0;
      case (st)
         0:  begin pcw = 1; srcb = 2'b01; end
         2:  begin ir = 1; mdr = 1; end
         3:  begin al = 1; bl = 1; srcb = 2'b11; aol = 1; end
         4:  begin srca = 1; aop = 2'b10; aol = 1; end
         5:  begin rw = 1; rd = 1; end
         6:  begin srca = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; bne = (op == 6'h05); end
         7:  begin srca = 1; srcb = 2'b10; aol = 1; end
         8:  begin iord = 1; mdr = last_lw; end
         9:  begin iord = 1; wr = 1; end
         10: begin rw = 1; m2r = 2'b01; end
         11: begin rw = 1; m2r = 2'b10; end
         12: begin pcw = 1; pcs = 2'b10; end
         13: hl = 1;
         14: il = 1;
         default: ;
      endcase
      pcl = pcw | (pcc & (zero ^ bne));
      if (in_rst) {pcl, pcw, pcc, wr, ir, mdr, al, bl, aol, rw} = '0;
      return {pcl, pcw, pcc, bne, iord, wr, m2r, ir, mdr, al, bl, aol, pcs, aop, srca, srcb, rw, rd, hl, il};
   endfunction

   task automatic check_all(input int c, input bit in_rst);
      for (int i = 0; i < 3; i++) begin
         int st;
         int nx;
         st = in_rst ? 0 : exps[i][c];
         nx = exps[i][c + 1];
         chk($sformatf("state mw%0d op%0h fn%0h c%0d", mw_of[i], op, funct, c), 32'(so[i]), 32'(st));
         chk($sformatf("ctrl mw%0d op%0h fn%0h c%0d st%0d", mw_of[i], op, funct, c, st),
             32'(obs[i]), 32'(exp_outs(st, (nx == 10), in_rst)));
      end
   endtask

   // One episode: reset, then run an instruction for ncyc cycles; optional async reset at rst_at
   task automatic run_ep(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int ncyc, input int rst_at);
      Reset = 1'b0;
      op = o;
      funct = f;
      zero = z;
      #1;
      check_all(0, 1'b1);
      @(posedge clk); #2;
      check_all(0, 1'b1);
      Reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) build(i, mw_of[i]);
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) begin
            @(posedge clk); #2;
         end
         check_all(c, 1'b0);
         if (c == rst_at) begin
            #3;
            Reset = 1'b0;
            #1;
            check_all(0, 1'b1);
            break;
         end
      end
   endtask

   initial begin
      tab_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h02};
      tab_fn = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h00, 6'h0D, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      #2;
      check_all(0, 1'b1);

      run_ep(6'h00, 6'h20, 1'b0, 24, -1);  // ADD
      run_ep(6'h04, 6'h00, 1'b1, 12, -1);  // BEQ taken
      run_ep(6'h05, 6'h00, 1'b1, 12, -1);  // BNE not taken
      run_ep(6'h05, 6'h00, 1'b0, 12, -1);  // BNE taken
      run_ep(6'h23, 6'h00, 1'b0, 24, -1);  // LW
      run_ep(6'h2B, 6'h00, 1'b0, 24, -1);  // SW
      run_ep(6'h3F, 6'h00, 1'b0, 16, -1);  // bad opcode
      run_ep(6'h00, 6'h0D, 1'b0, 16, -1);  // BREAK
      run_ep(6'h00, 6'h3F, 1'b0, 16, -1);  // bad funct
      run_ep(6'h23, 6'h00, 1'b0, 20, 7);   // reset while MEM_WAIT=3 instance is in LW_WAIT
      run_ep(6'h00, 6'h20, 1'b0, 12, -1);  // normal fetch after that reset
      run_ep(6'h0F, 6'h00, 1'b0, 16, -1);  // LUI
      run_ep(6'h02, 6'h00, 1'b1, 16, -1);  // J
      run_ep(6'h00, 6'h00, 1'b0, 16, -1);  // NOP

      for (int n = 0; n < 40; n++) begin
         int sel;
         int len;
         int ra;
         logic [5:0] ro;
         logic [5:0] rf;
         sel = $urandom_range(0, 13);
         if (sel < 12) begin
            ro = tab_op[sel];
            rf = tab_fn[sel];
         end else begin
            ro = 6'($urandom_range(0, 63));
            rf = 6'($urandom_range(0, 63));
         end
         len = $urandom_range(8, 40);
         ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         run_ep(ro, rf, 1'($urandom_range(0, 1)), len, ra);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
